// File: rtl/glitc_clock_edge_finder.sv
// GLITC clock-input phase alignment controller.
// Sweeps the IDELAY tap, counts high samples per tap, finds the first
// low-to-high transition and parks the delay a fixed offset past it.
module glitc_clock_edge_finder #(
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_BITS   = 8,
  parameter int EDGE_OFFSET   = 8,
  parameter int FAIL_TAP      = 0
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       sample_i,
  output logic [4:0] delay_o,
  output logic       load_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       locked_o,
  output logic       fail_o,
  output logic [4:0] edge_tap_o
);

  localparam int N  = 1 << SAMPLE_BITS;
  localparam int CW = SAMPLE_BITS + 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = (CW > SW) ? CW : SW;

  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] COUNT_LAST  = TW'(N - 1);
  localparam logic [CW-1:0] HIGH_TH     = CW'((3 * N) / 4);
  localparam logic [CW-1:0] LOW_TH      = CW'(N / 4);
  localparam logic [4:0]    OFFSET      = 5'(EDGE_OFFSET % 32);
  localparam logic [4:0]    FAIL_VAL    = 5'(FAIL_TAP % 32);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_COUNT,
    S_EVAL,
    S_APPLY,
    S_DONE
  } state_t;

  state_t        state;
  logic [4:0]    tap;
  logic [4:0]    cand;
  logic          cand_valid;
  logic          seen_low;
  logic [TW-1:0] timer;
  logic [CW-1:0] count;

  logic          is_high;
  logic          is_low;
  logic [4:0]    edge_sel;

  // Tap classification and edge choice, consumed only in EVAL
  always_comb begin
    is_high  = (count >= HIGH_TH);
    is_low   = (count <= LOW_TH);
    edge_sel = cand_valid ? cand : tap;
  end

  // Scan sequencer: all outputs are registered here
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= S_IDLE;
      tap        <= '0;
      cand       <= '0;
      cand_valid <= 1'b0;
      seen_low   <= 1'b0;
      timer      <= '0;
      count      <= '0;
      delay_o    <= '0;
      load_o     <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      locked_o   <= 1'b0;
      fail_o     <= 1'b0;
      edge_tap_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          load_o <= 1'b0;
          done_o <= 1'b0;
          if (start_i) begin
            locked_o   <= 1'b0;
            fail_o     <= 1'b0;
            edge_tap_o <= '0;
            seen_low   <= 1'b0;
            cand_valid <= 1'b0;
            tap        <= '0;
            delay_o    <= '0;
            load_o     <= 1'b1;
            busy_o     <= 1'b1;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          load_o <= 1'b0;
          timer  <= '0;
          state  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (timer == SETTLE_LAST) begin
            timer <= '0;
            count <= '0;
            state <= S_COUNT;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_COUNT: begin
          count <= count + CW'(sample_i);
          if (timer == COUNT_LAST) begin
            state <= S_EVAL;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_EVAL: begin
          if (is_high && seen_low) begin
            locked_o   <= 1'b1;
            edge_tap_o <= edge_sel;
            delay_o    <= edge_sel + OFFSET;
            load_o     <= 1'b1;
            state      <= S_APPLY;
          end else begin
            if (is_low) begin
              seen_low   <= 1'b1;
              cand_valid <= 1'b0;
            end else if (!is_high && seen_low && !cand_valid) begin
              cand       <= tap;
              cand_valid <= 1'b1;
            end
            if (tap == 5'd31) begin
              fail_o  <= 1'b1;
              delay_o <= FAIL_VAL;
              load_o  <= 1'b1;
              state   <= S_APPLY;
            end else begin
              tap     <= tap + 5'd1;
              delay_o <= tap + 5'd1;
              load_o  <= 1'b1;
              state   <= S_LOAD;
            end
          end
        end
        S_APPLY: begin
          load_o <= 1'b0;
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= S_DONE;
        end
        S_DONE: begin
          done_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glitc_clock_edge_finder.sv
// Self-checking bench for glitc_clock_edge_finder.
// sample_i is generated per tap from a table of "ones per counting window",
// placed inside the window using the documented per-tap timing.
module tb_glitc_clock_edge_finder;

  localparam int P = 16 + 256 + 2;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       start_i = 1'b0;
  logic       sample_i = 1'b0;
  logic [4:0] delay_o;
  logic       load_o;
  logic       busy_o;
  logic       done_o;
  logic       locked_o;
  logic       fail_o;
  logic [4:0] edge_tap_o;

  int checks = 0;
  int errors = 0;

  int gcyc = 0;
  int start_gc = 0;
  int srel;
  int sph;
  int tap_count [32];

  int         r_loads, r_done_at, r_last_cyc;
  logic [4:0] r_last_val, r_first, r_edge, r_after_delay;
  logic       r_busy1, r_load1, r_locked, r_fail, r_busy_done, r_busy_bad;
  logic       r_after_busy, r_after_load, r_after_done;
  logic [6:0] r_clear1;

  glitc_clock_edge_finder dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .start_i    (start_i),
    .sample_i   (sample_i),
    .delay_o    (delay_o),
    .load_o     (load_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .locked_o   (locked_o),
    .fail_o     (fail_o),
    .edge_tap_o (edge_tap_o)
  );

  // Free-running clock
  always #5 clk_i = ~clk_i;

  // Global cycle counter used for relative cycle numbering
  always @(posedge clk_i) gcyc <= gcyc + 1;

  // Sample source: first tap_count[tap] cycles of each counting window are high
  always @(negedge clk_i) begin
    srel = gcyc - start_gc;
    sph = ((srel - 1) % P) - 17;
    sample_i = (srel >= 1) && (sph >= 0) && (sph < tap_count[delay_o]);
  end

  // Reference outcome of a scan computed from the tap classification rules
  function automatic void model(output bit lk, output bit fl, output int edg,
                                output int fin, output int kend);
    bit seen;
    bit cv;
    int cand;
    bit hi;
    bit lo;
    seen = 0; cv = 0; cand = 0;
    lk = 0; fl = 0; edg = 0; fin = 0; kend = 31;
    for (int t = 0; t < 32; t++) begin
      hi = (tap_count[t] * 4 >= 3 * 256);
      lo = (tap_count[t] * 4 <= 256);
      if (hi && seen) begin
        edg = cv ? cand : t;
        lk = 1;
        fin = (edg + 8) % 32;
        kend = t;
        return;
      end
      if (lo) begin
        seen = 1;
        cv = 0;
      end else if (!hi && seen && !cv) begin
        cand = t;
        cv = 1;
      end
      if (t == 31) begin
        fl = 1;
        fin = 0;
      end
    end
  endfunction

  task automatic set_step(input int at);
    for (int t = 0; t < 32; t++) tap_count[t] = (t >= at) ? 256 : 0;
  endtask

  // Run one scan and record what the DUT did
  task automatic run_scan(input bit mid_start, input bit start_in_done);
    int rel;
    @(negedge clk_i);
    start_i = 1'b1;
    start_gc = gcyc;
    r_loads = 0; r_done_at = -1; r_last_cyc = -1; r_last_val = '0;
    r_busy_bad = 1'b0;
    for (int i = 0; i < 9000; i++) begin
      @(negedge clk_i);
      rel = gcyc - start_gc;
      start_i = mid_start && (rel == 1000);
      if (rel == 1) begin
        r_busy1 = busy_o; r_load1 = load_o; r_first = delay_o;
        r_clear1 = {locked_o, fail_o, edge_tap_o};
      end
      if (load_o) begin
        r_loads++; r_last_cyc = rel; r_last_val = delay_o;
      end
      if (!busy_o && !done_o) r_busy_bad = 1'b1;
      if (done_o) begin
        r_done_at = rel; r_busy_done = busy_o;
        r_locked = locked_o; r_fail = fail_o; r_edge = edge_tap_o;
        break;
      end
    end
    start_i = start_in_done;
    @(negedge clk_i);
    start_i = 1'b0;
    r_after_busy = busy_o; r_after_load = load_o;
    r_after_done = done_o; r_after_delay = delay_o;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    checks++; if ({delay_o, load_o, busy_o, done_o, locked_o, fail_o, edge_tap_o} !== 15'd0) begin errors++; $display("FAIL reset_held outputs got %h want 0", {delay_o, load_o, busy_o, done_o, locked_o, fail_o, edge_tap_o}); end
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
    checks++; if ({delay_o, load_o, busy_o, done_o, locked_o, fail_o, edge_tap_o} !== 15'd0) begin errors++; $display("FAIL reset_idle outputs got %h want 0", {delay_o, load_o, busy_o, done_o, locked_o, fail_o, edge_tap_o}); end
  endtask

  task automatic test_edge_basic();
    set_step(10);
    run_scan(1'b0, 1'b0);
    checks++; if (r_load1 !== 1'b1 || r_first !== 5'd0 || r_busy1 !== 1'b1) begin errors++; $display("FAIL basic.first_load got load=%b delay=%0d busy=%b want 1/0/1", r_load1, r_first, r_busy1); end
    checks++; if (r_edge !== 5'd10 || r_locked !== 1'b1 || r_fail !== 1'b0) begin errors++; $display("FAIL basic.edge got edge=%0d lk=%b fl=%b want 10/1/0", r_edge, r_locked, r_fail); end
    checks++; if (r_last_cyc !== 3015 || r_last_val !== 5'd18) begin errors++; $display("FAIL basic.final_load got cyc=%0d val=%0d want 3015/18", r_last_cyc, r_last_val); end
    checks++; if (r_done_at !== 3016 || r_busy_done !== 1'b0) begin errors++; $display("FAIL basic.done got cyc=%0d busy=%b want 3016/0", r_done_at, r_busy_done); end
    checks++; if (r_busy_bad !== 1'b0 || r_loads !== 12) begin errors++; $display("FAIL basic.busy_loads got busy_gap=%b loads=%0d want 0/12", r_busy_bad, r_loads); end
    checks++; if (r_after_done !== 1'b0 || r_after_delay !== 5'd18 || r_after_busy !== 1'b0) begin errors++; $display("FAIL basic.hold got done=%b delay=%0d busy=%b want 0/18/0", r_after_done, r_after_delay, r_after_busy); end
  endtask

  task automatic test_mixed_edge();
    set_step(13);
    tap_count[12] = 128;
    run_scan(1'b0, 1'b0);
    checks++; if (r_edge !== 5'd12 || r_last_val !== 5'd20 || r_locked !== 1'b1) begin errors++; $display("FAIL mixed.edge got edge=%0d final=%0d lk=%b want 12/20/1", r_edge, r_last_val, r_locked); end
    checks++; if (r_done_at !== 14 * P + 2) begin errors++; $display("FAIL mixed.done got %0d want %0d", r_done_at, 14 * P + 2); end
  endtask

  task automatic test_wraparound();
    set_step(28);
    run_scan(1'b0, 1'b0);
    checks++; if (r_edge !== 5'd28 || r_last_val !== 5'd4 || r_locked !== 1'b1) begin errors++; $display("FAIL wrap.edge got edge=%0d final=%0d lk=%b want 28/4/1", r_edge, r_last_val, r_locked); end
  endtask

  task automatic test_no_edge();
    set_step(0);
    run_scan(1'b0, 1'b0);
    checks++; if (r_fail !== 1'b1 || r_locked !== 1'b0 || r_last_val !== 5'd0 || r_edge !== 5'd0) begin errors++; $display("FAIL noedge.flags got fl=%b lk=%b final=%0d edge=%0d want 1/0/0/0", r_fail, r_locked, r_last_val, r_edge); end
    checks++; if (r_done_at !== 8770 || r_loads !== 33) begin errors++; $display("FAIL noedge.timing got done=%0d loads=%0d want 8770/33", r_done_at, r_loads); end
  endtask

  task automatic test_cand_cleared();
    set_step(7);
    tap_count[5] = 128;
    run_scan(1'b0, 1'b0);
    checks++; if (r_edge !== 5'd7 || r_last_val !== 5'd15) begin errors++; $display("FAIL cand_clear.edge got edge=%0d final=%0d want 7/15", r_edge, r_last_val); end
  endtask

  task automatic test_thresholds();
    set_step(5);
    tap_count[0] = 192; tap_count[1] = 64; tap_count[2] = 65;
    tap_count[3] = 191; tap_count[4] = 192;
    run_scan(1'b0, 1'b0);
    checks++; if (r_edge !== 5'd2 || r_last_val !== 5'd10 || r_locked !== 1'b1) begin errors++; $display("FAIL thresh.edge got edge=%0d final=%0d lk=%b want 2/10/1", r_edge, r_last_val, r_locked); end
    checks++; if (r_done_at !== 5 * P + 2) begin errors++; $display("FAIL thresh.done got %0d want %0d", r_done_at, 5 * P + 2); end
  endtask

  task automatic test_mid_start();
    set_step(10);
    run_scan(1'b1, 1'b0);
    checks++; if (r_done_at !== 3016 || r_loads !== 12 || r_edge !== 5'd10) begin errors++; $display("FAIL mid_start got done=%0d loads=%0d edge=%0d want 3016/12/10", r_done_at, r_loads, r_edge); end
  endtask

  task automatic test_back_to_back();
    set_step(3);
    run_scan(1'b0, 1'b1);
    checks++; if (r_after_busy !== 1'b0 || r_after_load !== 1'b0 || r_after_delay !== 5'd11) begin errors++; $display("FAIL b2b.start_in_done got busy=%b load=%b delay=%0d want 0/0/11", r_after_busy, r_after_load, r_after_delay); end
    set_step(5);
    run_scan(1'b0, 1'b0);
    checks++; if (r_clear1 !== 7'd0 || r_busy1 !== 1'b1) begin errors++; $display("FAIL b2b.clear got flags=%h busy=%b want 0/1", r_clear1, r_busy1); end
    checks++; if (r_edge !== 5'd5 || r_done_at !== 6 * P + 2) begin errors++; $display("FAIL b2b.second got edge=%0d done=%0d want 5/%0d", r_edge, r_done_at, 6 * P + 2); end
  endtask

  task automatic test_async_reset();
    int rel;
    set_step(10);
    @(negedge clk_i);
    start_i = 1'b1;
    start_gc = gcyc;
    @(negedge clk_i);
    start_i = 1'b0;
    rel = 1;
    while (rel < 18 + 2 * P + 50) begin
      @(negedge clk_i);
      rel = gcyc - start_gc;
    end
    checks++; if (busy_o !== 1'b1 || delay_o !== 5'd2) begin errors++; $display("FAIL areset.pre got busy=%b delay=%0d want 1/2", busy_o, delay_o); end
    #2 rst_n_i = 1'b0;
    #1;
    checks++; if ({delay_o, load_o, busy_o, done_o, locked_o, fail_o, edge_tap_o} !== 15'd0) begin errors++; $display("FAIL areset.outputs got %h want 0", {delay_o, load_o, busy_o, done_o, locked_o, fail_o, edge_tap_o}); end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    run_scan(1'b0, 1'b0);
    checks++; if (r_first !== 5'd0 || r_done_at !== 3016 || r_edge !== 5'd10 || r_loads !== 12) begin errors++; $display("FAIL areset.rescan got first=%0d done=%0d edge=%0d loads=%0d want 0/3016/10/12", r_first, r_done_at, r_edge, r_loads); end
  endtask

  task automatic test_random();
    int pool [9] = '{0, 32, 64, 65, 128, 191, 192, 224, 256};
    int idx;
    bit lk, fl;
    int edg, fin, kend;
    for (int it = 0; it < 3; it++) begin
      for (int t = 0; t < 32; t++) begin
        idx = $urandom_range(0, 9);
        tap_count[t] = (idx == 9) ? $urandom_range(0, 256) : pool[idx];
      end
      model(lk, fl, edg, fin, kend);
      run_scan(it == 1, 1'b0);
      checks++; if (r_locked !== lk || r_fail !== fl || r_edge !== 5'(edg)) begin errors++; $display("FAIL rand%0d.result got lk=%b fl=%b edge=%0d want %b/%b/%0d", it, r_locked, r_fail, r_edge, lk, fl, edg); end
      checks++; if (r_last_val !== 5'(fin) || r_last_cyc !== P * (kend + 1) + 1) begin errors++; $display("FAIL rand%0d.final got val=%0d cyc=%0d want %0d/%0d", it, r_last_val, r_last_cyc, fin, P * (kend + 1) + 1); end
      checks++; if (r_done_at !== P * (kend + 1) + 2 || r_loads !== kend + 2 || r_busy_bad !== 1'b0) begin errors++; $display("FAIL rand%0d.timing got done=%0d loads=%0d gap=%b want %0d/%0d/0", it, r_done_at, r_loads, r_busy_bad, P * (kend + 1) + 2, kend + 2); end
    end
  endtask

  // Test sequence
  initial begin
    for (int t = 0; t < 32; t++) tap_count[t] = 0;
    test_reset();
    test_edge_basic();
    test_mixed_edge();
    test_wraparound();
    test_no_edge();
    test_cand_cleared();
    test_thresholds();
    test_mid_start();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/glitc_clock_edge_finder.md
# glitc_clock_edge_finder

Automatic phase-alignment controller for the GLITC clock-input path. It sweeps the 5-bit IDELAY tap on the negative clock leg and counts how often the IFD-sampled value is high at each tap. It finds the first low-to-high transition of the sampled clock and parks the delay a fixed offset past that edge, so the sampling clock sits in a stable region. It sits beside the clock-path wrapper and drives its delay value/load pair in place of manual register writes.

## Interface
- SETTLE_CYCLES, 16: idle cycles after each tap load before counting.
- SAMPLE_BITS, 8: N = 2^SAMPLE_BITS samples counted per tap.
- EDGE_OFFSET, 8: taps added to the found edge tap (mod 32) to form the final tap.
- FAIL_TAP, 0: tap loaded when no edge is found.

Ports:
- clk_i  in  1  sole clock (SYSCLK_DIV2_PS domain).
- rst_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle scan request; honoured only in IDLE.
- sample_i  in  1  negative-leg IFD output, already synchronous to clk_i.
- delay_o  out  5  IDELAY tap value.
- load_o  out  1  one-cycle load strobe; delay_o is valid in the same cycle.
- busy_o  out  1  high from the cycle after an accepted start until DONE.
- done_o  out  1  one-cycle pulse at scan completion.
- locked_o  out  1  edge found; holds until the next accepted start.
- fail_o  out  1  no edge found; holds until the next accepted start.
- edge_tap_o  out  5  detected edge tap; holds until the next accepted start.

## Operation
- Reset values: all outputs 0, state IDLE, tap 0.
- States:
  - IDLE: start_i=1 clears locked_o, fail_o, edge_tap_o, seen_low and cand_valid, sets tap=0, and moves to LOAD.
  - LOAD (1 cycle): load_o=1, delay_o=tap, go to SETTLE.
  - SETTLE (SETTLE_CYCLES cycles): go to COUNT.
  - COUNT (N cycles): count += sample_i. Counter width is SAMPLE_BITS+1, so all-ones gives count=N with no overflow.
  - EVAL (1 cycle): classify the tap, then update the edge search.
  - APPLY (1 cycle): load_o=1 with the final tap.
  - DONE (1 cycle): done_o=1, then IDLE.
- Classification: HIGH if count ≥ 3N/4; LOW if count ≤ N/4; otherwise MIXED.
- Edge search in EVAL:
  - LOW: seen_low=1 and cand_valid=0.
  - MIXED with seen_low=1 and cand_valid=0: cand=tap, cand_valid=1.
  - HIGH with seen_low=1: edge = cand if cand_valid, else tap. Set locked_o=1, edge_tap_o=edge, final tap=(edge+EDGE_OFFSET) mod 32, and go to APPLY (early termination).
  - HIGH with seen_low=0: no action.
  - Otherwise, if tap=31: fail_o=1, final tap=FAIL_TAP, go to APPLY.
  - Otherwise: tap+1, then LOAD.
- Tap 0 can never be an edge, because a LOW must be seen first.
- delay_o holds its last loaded value between loads and after DONE.
- start_i while busy is ignored; no queuing.
- Reset asserted in any state returns the block to reset values immediately. The IDELAY keeps its last loaded tap until the next load_o.

## Timing
- Per-tap period P = SETTLE_CYCLES + N + 2 (274 with defaults).
- Cycle numbering: start_i high at cycle 0.
  - LOAD for tap k at cycle 1 + kP.
  - EVAL for tap k at cycle P(k+1).
  - APPLY at P(k+1)+1.
  - DONE (done_o, busy_o falls) at P(k+1)+2.
- locked_o, fail_o and edge_tap_o update at the EVAL clock edge, so they are visible from APPLY onward.
- Worst case (fail): done_o at 32P+2 = 8770 cycles with defaults.
- A start_i in the DONE cycle is ignored; start_i is accepted from the first IDLE cycle onward.

## Test plan
- sample_i = (delay_o ≥ 10):
  - edge_tap_o=10, locked_o=1.
  - Final load_o at cycle 3015 with delay_o=18; done_o at 3016.
- Tap 12 driven with a 50% toggle, taps <12 low, taps >12 high:
  - Edge is the MIXED tap 12; final delay_o=20, locked_o=1.
- Wrap-around, with taps <28 low and taps ≥28 high:
  - edge_tap_o=28, final delay_o=4.
- sample_i constant 1:
  - fail_o=1, locked_o=0, final delay_o=0.
  - done_o at cycle 8770; 33 load_o pulses in total.
- LOW taps 0–4, MIXED tap 5, LOW tap 6, HIGH tap 7:
  - Candidate is cleared by tap 6, so edge_tap_o=7 and final delay_o=15.
- start_i pulsed mid-scan: no restart, timing unchanged.
- rst_n_i asserted mid-COUNT: all outputs 0 within the same cycle.
  - A following start runs a full scan from tap 0.
